// File: rtl/fp_sqrt_seq.sv
// fp_sqrt_seq: sequential IEEE-754 single-precision square root, radix-2 restoring recurrence,
// one root bit per clock, fixed 26-clock latency from the accepting edge to done.
module fp_sqrt_seq #(
    parameter logic [31:0] NAN_CODE = 32'h7FC0_0000,
    parameter int          N_ITER   = 25
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] A,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        invalid
);
    typedef enum logic [1:0] {IDLE, ITER, PACK} state_t;
    state_t state, state_nx;
    logic [4:0]  cnt;
    logic [49:0] rad;
    logic [25:0] rem;
    logic [24:0] root;
    logic [7:0]  exp_q;
    logic        spec, spec_inv;
    logic [31:0] spec_res;
    logic        acc, ld, last;
    logic        a_zero, a_nan, a_inf, u_spec, u_inv;
    logic [31:0] u_res;
    logic [49:0] u_rad;
    logic [7:0]  u_exp;
    logic [27:0] tri_rem, sub;
    logic        ge, up;

    always_ff @(posedge CLK)
        if (RST) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        last     = cnt == 5'(N_ITER - 1);
        state_nx = state == IDLE ? (start ? ITER : IDLE) :
                   state == ITER ? (last ? PACK : ITER) : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
        acc  = state == IDLE && start;
        ld   = state == PACK;
    end

    // Classification: denormals flush to signed zero before the sign test, so -denormal gives -0.
    always_comb begin
        a_zero   = A[30:23] == 8'd0;
        a_nan    = A[30:23] == 8'hFF && A[22:0] != 23'd0;
        a_inf    = A[30:23] == 8'hFF && A[22:0] == 23'd0;
        u_spec   = a_zero | a_nan | a_inf | A[31];
        u_inv    = !a_zero && (a_nan || A[31]);
        u_res    = a_zero ? {A[31], 31'd0} : (a_nan || A[31]) ? NAN_CODE : 32'h7F80_0000;
        u_rad    = A[23] ? {2'b01, A[22:0], 25'd0} : {1'b1, A[22:0], 26'd0};
        u_exp    = 8'((9'(A[30:23]) + 9'd127) >> 1);
    end

    always_comb begin
        tri_rem = {rem, rad[49:48]};
        sub     = {1'b0, root, 2'b01};
        ge      = tri_rem >= sub;
        up      = root[0] & ((|rem) | root[1]);
    end

    always_ff @(posedge CLK)
        if (RST) begin
            result   <= '0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            root     <= '0;
            rad      <= '0;
            exp_q    <= '0;
            spec     <= 1'b0;
            spec_inv <= 1'b0;
            spec_res <= '0;
        end else begin
            if (acc) begin
                rad      <= u_rad;
                rem      <= '0;
                root     <= '0;
                cnt      <= '0;
                exp_q    <= u_exp;
                spec     <= u_spec;
                spec_inv <= u_inv;
                spec_res <= u_res;
            end else if (state == ITER) begin
                rad  <= rad << 2;
                rem  <= 26'(ge ? tri_rem - sub : tri_rem);
                root <= {root[23:0], ge};
                cnt  <= cnt + 5'd1;
            end
            done <= ld;
            if (ld) begin
                result  <= spec ? spec_res : {1'b0, exp_q, root[23:1] + 23'(up)};
                invalid <= spec & spec_inv;
            end
        end
endmodule

// File: tb/tb_fp_sqrt_seq.sv
// tb_fp_sqrt_seq: directed vector table, hand-written handshake/reset sequences and a
// random sweep of normal operands against a double-precision reference.
module tb_fp_sqrt_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, result;
    logic        done, busy, invalid;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        logic        inv;
    } vec_t;
    vec_t tv[16];

    fp_sqrt_seq dut (
        .CLK(clk), .RST(rst), .start(start), .A(a),
        .result(result), .done(done), .busy(busy), .invalid(invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Correctly rounded sqrt of a normal positive single via double precision, then RNE to single.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        logic [51:0] f;
        logic [30:0] m;
        logic        rnd;
        d   = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        d   = $realtobits($sqrt($bitstoreal(d)));
        e   = d[62:52];
        f   = d[51:0];
        m   = {8'(e - 11'd896), f[51:29]};
        rnd = f[28] & ((|f[27:0]) | f[29]);
        return {1'b0, m + 31'(rnd)};
    endfunction

    task automatic wait_done(input bit keep, inout int n, inout int bc);
        do begin
            @(negedge clk);
            if (!keep) start = 1'b0;
            n++;
            if (!done) bc += int'(busy);
        end while (!done && n < 60);
    endtask

    task automatic run_op(input logic [31:0] x, output logic [31:0] r, output logic inv,
                          output int n, output int bc);
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        a     = x;
        start = 1'b1;
        @(posedge clk);
        n  = 0;
        bc = 0;
        wait_done(1'b0, n, bc);
        r   = result;
        inv = invalid;
    endtask

    initial begin
        logic [31:0] r, x;
        logic        inv;
        int          n, bc, nd;
        tv[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0};
        tv[1]  = '{32'h4110_0000, 32'h4040_0000, 1'b0};
        tv[2]  = '{32'h4000_0000, 32'h3FB5_04F3, 1'b0};
        tv[3]  = '{32'h0080_0000, 32'h2000_0000, 1'b0};
        tv[4]  = '{32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0};
        tv[5]  = '{32'h3F80_0001, 32'h3F80_0000, 1'b0};
        tv[6]  = '{32'h3E80_0000, 32'h3F00_0000, 1'b0};
        tv[7]  = '{32'hBF80_0000, 32'h7FC0_0000, 1'b1};
        tv[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0};
        tv[9]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0};
        tv[10] = '{32'h7FA0_0000, 32'h7FC0_0000, 1'b1};
        tv[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0};
        tv[12] = '{32'h8000_0001, 32'h8000_0000, 1'b0};
        tv[13] = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1};
        tv[14] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        tv[15] = '{32'hFFC0_0000, 32'h7FC0_0000, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_result", result, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_invalid", 32'(invalid), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(tv[i].a, r, inv, n, bc);
            chk($sformatf("vec%0d_result", i), r, tv[i].r);
            chk($sformatf("vec%0d_invalid", i), 32'(inv), 32'(tv[i].inv));
            chk($sformatf("vec%0d_latency", i), 32'(n - 1), 32'd26);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd26);
            chk($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
        end

        // Back-to-back: start held high (with a new A) while busy; first result must be unaffected.
        @(negedge clk);
        a     = 32'h4110_0000;
        start = 1'b1;
        @(posedge clk);
        n  = 0;
        bc = 0;
        repeat (4) begin
            @(negedge clk);
            n++;
            bc += int'(busy);
        end
        a = 32'h4000_0000;
        wait_done(1'b1, n, bc);
        chk("b2b_first_result", result, 32'h4040_0000);
        chk("b2b_first_latency", 32'(n - 1), 32'd26);
        chk("b2b_first_busy", 32'(bc), 32'd26);
        n  = 0;
        bc = 0;
        wait_done(1'b0, n, bc);
        chk("b2b_second_result", result, 32'h3FB5_04F3);
        chk("b2b_second_latency", 32'(n - 1), 32'd26);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        a     = 32'h4080_0000;
        start = 1'b1;
        @(posedge clk);
        repeat (9) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_result", result, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_invalid", 32'(invalid), 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_op(32'h4110_0000, r, inv, n, bc);
        chk("post_abort_result", r, 32'h4040_0000);
        chk("post_abort_latency", 32'(n - 1), 32'd26);

        for (int i = 0; i < 600; i++) begin
            x = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
            run_op(x, r, inv, n, bc);
            chk($sformatf("rand%0d_%h", i, x), r, ref_sqrt(x));
            chk($sformatf("rand%0d_latency", i), 32'(n - 1), 32'd26);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
